// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add step: adds (or, on the signed final step, subtracts) the
// multiplicand shifted by the step index when the current multiplier bit is set.
module mult_step #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CW     = 3,
  parameter int unsigned SIGNED = 0
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mcand_ext,
  input  logic             b_lsb,
  input  logic [CW-1:0]    cnt,
  input  logic             last,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted  = mcand_ext << cnt;
    acc_next = acc;
    if (b_lsb) begin
      // Two's-complement multiplier: the top bit carries negative weight.
      if ((SIGNED != 0) && last) begin
        acc_next = acc - shifted;
      end else begin
        acc_next = acc + shifted;
      end
    end
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// Optional MULT_EARLY_TERM_EN ends the iteration once the remaining multiplier bits are zero.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH_A = 8,
  parameter int unsigned WIDTH_B = 8,
  parameter int unsigned SIGNED  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] z
);

  localparam int unsigned W  = WIDTH_A + WIDTH_B;
  localparam int unsigned CW = (clog2(WIDTH_B) < 1) ? 1 : clog2(WIDTH_B);

  mult_state_t        state_q, state_d;
  logic [WIDTH_A-1:0] mcand_q, mcand_d;
  logic [WIDTH_B-1:0] mplier_q, mplier_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [W-1:0]       z_q, z_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [W-1:0]       mcand_ext;
  logic [W-1:0]       acc_step;
  logic               last;
  logic               finish;

  always_comb begin
    if (SIGNED != 0) begin
      mcand_ext = {{WIDTH_B{mcand_q[WIDTH_A-1]}}, mcand_q};
    end else begin
      mcand_ext = {{WIDTH_B{1'b0}}, mcand_q};
    end
  end

  assign last = (cnt_q == CW'(WIDTH_B - 1));

  mult_step #(
    .WIDTH  (W),
    .CW     (CW),
    .SIGNED (SIGNED)
  ) u_step (
    .acc       (acc_q),
    .mcand_ext (mcand_ext),
    .b_lsb     (mplier_q[0]),
    .cnt       (cnt_q),
    .last      (last),
    .acc_next  (acc_step)
  );

`ifdef MULT_EARLY_TERM_EN
  // Nothing left to add once the unconsumed multiplier bits are all zero.
  assign finish = last || (mplier_q[WIDTH_B-1:1] == '0);
`else
  assign finish = last;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (finish) begin
          z_d     = acc_step;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      z_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign z         = z_q;

endmodule
